// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the instruction/data memory
//                arbiter: FSM state encoding, port identifiers, default
//                bus widths and a small saturating-count helper.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    localparam int c_ADDR_W = 30;
    localparam int c_DATA_W = 32;

    // Identifies which processor port owns the access in flight
    localparam logic c_PORT_INST = 1'b0;
    localparam logic c_PORT_DATA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Increment a 4-bit count but never beyond the given ceiling
    function automatic logic [3:0] sat_inc(input logic [3:0] cnt, input logic [3:0] ceil);
        sat_inc = (cnt >= ceil) ? ceil : cnt + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_wdog.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_wdog
//  Description : Access watchdog. Loaded when an access is granted, counts
//                down while the access waits for the memory, and flags expiry
//                in the TIMEOUT-th waiting cycle. TIMEOUT=0 removes it.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arb_wdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expire
);

    // Counter only needs to hold TIMEOUT-1
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    generate
        if (TIMEOUT > 0) begin : g_wdog
            localparam logic [CNT_W-1:0] c_LOAD = CNT_W'(TIMEOUT - 1);

            logic [CNT_W-1:0] r_cnt;

            // Down-counter: reload on grant, step once per waiting cycle
            always_ff @(posedge clk) begin
                if (rst || i_clear) begin
                    r_cnt <= '0;
                end else if (i_load) begin
                    r_cnt <= c_LOAD;
                end else if (i_en && (r_cnt != '0)) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end

            assign o_expire = i_en && (r_cnt == '0);
        end else begin : g_nowdog
            logic w_unused;
            assign w_unused = ^{clk, rst, i_load, i_clear, i_en};
            assign o_expire = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one single-ported memory between the instruction
//                fetch port and the data port. Data has priority, but a
//                waiting fetch wins after STARVE_LIMIT consecutive data
//                grants. Each access is IDLE -> ACCESS -> RESP; a missing
//                Mem_Ack aborts after TIMEOUT cycles with Bus_Error.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = c_ADDR_W,
    parameter int DATA_W       = c_DATA_W,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              clock,
    input  logic              reset,
    // instruction fetch port
    input  logic              InstMem_Read,
    input  logic [ADDR_W-1:0] InstMem_Address,
    output logic [DATA_W-1:0] InstMem_In,
    output logic              InstMem_Ready,
    // data port
    input  logic              DataMem_Read,
    input  logic [3:0]        DataMem_Write,
    input  logic [ADDR_W-1:0] DataMem_Address,
    input  logic [DATA_W-1:0] DataMem_Out,
    output logic [DATA_W-1:0] DataMem_In,
    output logic              DataMem_Ready,
    // memory side
    output logic              Mem_Req,
    output logic [3:0]        Mem_Write,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [DATA_W-1:0] Mem_WData,
    input  logic [DATA_W-1:0] Mem_RData,
    input  logic              Mem_Ack,
    output logic              Bus_Error
);

    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_LIMIT);

    // registered state
    state_t              r_state;
    logic                r_port;
    logic [3:0]          r_starve;
    logic                r_mem_req;
    logic [3:0]          r_mem_write;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_inst_rdy;
    logic [DATA_W-1:0]   r_inst_rdata;
    logic                r_data_rdy;
    logic [DATA_W-1:0]   r_data_rdata;
    logic                r_bus_err;

    // next-state values
    state_t              w_nxt_state;
    logic                w_nxt_port;
    logic [3:0]          w_nxt_starve;
    logic                w_nxt_mem_req;
    logic [3:0]          w_nxt_mem_write;
    logic [ADDR_W-1:0]   w_nxt_mem_addr;
    logic [DATA_W-1:0]   w_nxt_mem_wdata;
    logic                w_nxt_inst_rdy;
    logic [DATA_W-1:0]   w_nxt_inst_rdata;
    logic                w_nxt_data_rdy;
    logic [DATA_W-1:0]   w_nxt_data_rdata;
    logic                w_nxt_bus_err;

    // arbitration and watchdog helpers
    logic                w_inst_req;
    logic                w_data_req;
    logic                w_inst_win;
    logic [DATA_W-1:0]   w_rsp_data;
    logic                w_wd_load;
    logic                w_wd_clear;
    logic                w_wd_en;
    logic                w_wd_expire;
    logic                w_rst;

    assign w_rst      = ~reset;
    assign w_inst_req = InstMem_Read;
    assign w_data_req = DataMem_Read | (|DataMem_Write);
    // Data normally wins; a fetch that has watched STARVE_LIMIT data grants goes first
    assign w_inst_win = w_inst_req && (!w_data_req || (r_starve >= c_STARVE_MAX));
    // Writes return no data, and an aborted access returns zero
    assign w_rsp_data = (Mem_Ack && (r_mem_write == 4'b0000)) ? Mem_RData : '0;
    assign w_wd_en    = (r_state == ST_ACCESS);

    mem_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (clock),
        .rst      (w_rst),
        .i_load   (w_wd_load),
        .i_clear  (w_wd_clear),
        .i_en     (w_wd_en),
        .o_expire (w_wd_expire)
    );

    // Next-state and next-output decode for the IDLE/ACCESS/RESP sequence
    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_port       = r_port;
        w_nxt_starve     = r_starve;
        w_nxt_mem_req    = r_mem_req;
        w_nxt_mem_write  = r_mem_write;
        w_nxt_mem_addr   = r_mem_addr;
        w_nxt_mem_wdata  = r_mem_wdata;
        w_nxt_inst_rdy   = 1'b0;
        w_nxt_inst_rdata = '0;
        w_nxt_data_rdy   = 1'b0;
        w_nxt_data_rdata = '0;
        w_nxt_bus_err    = 1'b0;
        w_wd_load        = 1'b0;
        w_wd_clear       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_inst_req || w_data_req) begin
                    w_nxt_state   = ST_ACCESS;
                    w_nxt_mem_req = 1'b1;
                    w_wd_load     = 1'b1;
                    if (w_inst_win) begin
                        w_nxt_port      = c_PORT_INST;
                        w_nxt_mem_addr  = InstMem_Address;
                        w_nxt_mem_write = 4'b0000;
                        w_nxt_mem_wdata = '0;
                        w_nxt_starve    = 4'd0;
                    end else begin
                        w_nxt_port      = c_PORT_DATA;
                        w_nxt_mem_addr  = DataMem_Address;
                        // a simultaneous read and write is served as the write
                        w_nxt_mem_write = DataMem_Write;
                        w_nxt_mem_wdata = (|DataMem_Write) ? DataMem_Out : '0;
                        w_nxt_starve    = w_inst_req ? sat_inc(r_starve, c_STARVE_MAX) : 4'd0;
                    end
                end
            end

            ST_ACCESS: begin
                // an acknowledge in the expiry cycle still counts as success
                if (Mem_Ack || w_wd_expire) begin
                    w_nxt_state     = ST_RESP;
                    w_nxt_mem_req   = 1'b0;
                    w_nxt_mem_write = 4'b0000;
                    w_nxt_mem_addr  = '0;
                    w_nxt_mem_wdata = '0;
                    w_nxt_bus_err   = ~Mem_Ack;
                    w_wd_clear      = 1'b1;
                    if (r_port == c_PORT_INST) begin
                        w_nxt_inst_rdy   = 1'b1;
                        w_nxt_inst_rdata = w_rsp_data;
                    end else begin
                        w_nxt_data_rdy   = 1'b1;
                        w_nxt_data_rdata = w_rsp_data;
                    end
                end
            end

            ST_RESP: begin
                // the completing request is still high here, so do not sample
                w_nxt_state = ST_IDLE;
            end

            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_port       <= c_PORT_INST;
            r_starve     <= 4'd0;
            r_mem_req    <= 1'b0;
            r_mem_write  <= 4'b0000;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_inst_rdy   <= 1'b0;
            r_inst_rdata <= '0;
            r_data_rdy   <= 1'b0;
            r_data_rdata <= '0;
            r_bus_err    <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_port       <= w_nxt_port;
            r_starve     <= w_nxt_starve;
            r_mem_req    <= w_nxt_mem_req;
            r_mem_write  <= w_nxt_mem_write;
            r_mem_addr   <= w_nxt_mem_addr;
            r_mem_wdata  <= w_nxt_mem_wdata;
            r_inst_rdy   <= w_nxt_inst_rdy;
            r_inst_rdata <= w_nxt_inst_rdata;
            r_data_rdy   <= w_nxt_data_rdy;
            r_data_rdata <= w_nxt_data_rdata;
            r_bus_err    <= w_nxt_bus_err;
        end
    end

    assign Mem_Req       = r_mem_req;
    assign Mem_Write     = r_mem_write;
    assign Mem_Address   = r_mem_addr;
    assign Mem_WData     = r_mem_wdata;
    assign InstMem_Ready = r_inst_rdy;
    assign InstMem_In    = r_inst_rdata;
    assign DataMem_Ready = r_data_rdy;
    assign DataMem_In    = r_data_rdata;
    assign Bus_Error     = r_bus_err;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between the processor's instruction-fetch port (InstMem_*) and its data port (DataMem_*).
- Sits between Processor and the backing memory model or SRAM wrapper.
- Serialises requests with data-priority arbitration, bounded instruction starvation and a per-access timeout.
- Returns per-port Ready pulses matching the processor's hold-until-Ready protocol.

Parameters:
- ADDR_W, 30, word address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, max consecutive data grants while a fetch waits; range 1..15.
- TIMEOUT, 255, cycles to wait for Mem_Ack before aborting; 0 disables the timeout.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- InstMem_Read  in  1  fetch request, held until InstMem_Ready.
- InstMem_Address  in  ADDR_W  fetch word address.
- InstMem_In  out  DATA_W  fetched word, valid while InstMem_Ready=1.
- InstMem_Ready  out  1  one-cycle completion pulse.
- DataMem_Read  in  1  load request, held until DataMem_Ready.
- DataMem_Write  in  4  byte-enable store request; nonzero means write. Held until DataMem_Ready.
- DataMem_Address  in  ADDR_W  data word address.
- DataMem_Out  in  DATA_W  store data from the processor.
- DataMem_In  out  DATA_W  load data, valid while DataMem_Ready=1.
- DataMem_Ready  out  1  one-cycle completion pulse.
- Mem_Req  out  1  memory request, held until Mem_Ack is sampled.
- Mem_Write  out  4  byte enables; 0 means read.
- Mem_Address  out  ADDR_W  memory word address.
- Mem_WData  out  DATA_W  write data.
- Mem_RData  in  DATA_W  read data, valid while Mem_Ack=1.
- Mem_Ack  in  1  memory completion, one cycle.
- Bus_Error  out  1  one-cycle pulse, coincident with Ready, when an access timed out.

Behaviour:
- Reset (reset=0 at a rising edge):
  - State goes to IDLE.
  - All outputs go to 0, including data buses.
  - Starvation counter and timeout counter clear.
  - Reset arriving mid-access drops Mem_Req on the next edge; no Ready is issued.
- All outputs are registered.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Samples requests; a data request is DataMem_Read | (|DataMem_Write).
  - Grant rule: data wins unless the inst request is pending and starve_cnt == STARVE_LIMIT, in which case inst wins.
  - On grant: latch port id, address, Mem_Write (0 for inst or data read), and WData.
  - Assert Mem_Req and go to ACCESS.
  - Nothing pending: stay in IDLE.
- ACCESS:
  - Mem_Req and address/data/enables stay stable.
  - Mem_Ack sampled high: capture Mem_RData, go to RESP.
  - Timeout counter reaches TIMEOUT (TIMEOUT≠0): go to RESP with read data 0 and Bus_Error set.
- RESP:
  - Mem_Req=0.
  - Ready of the granted port = 1 for exactly this cycle, with its read-data bus driven. Write grants drive data 0.
  - Next state is always IDLE.
  - Requests are never sampled in RESP: the completing request is still asserted this cycle.
- Latency: zero-wait memory (Mem_Ack in the first ACCESS cycle) gives request sampled at edge N → Ready high in the cycle after edge N+1, i.e. 2 cycles. Each memory wait state adds 1 cycle.
- Throughput: at most one access per 3 cycles (IDLE→ACCESS→RESP).
- Starvation counter (4-bit):
  - Increments on a data grant while an inst request is pending.
  - Clears on any inst grant, and on a data grant with no inst pending.
  - Saturates at STARVE_LIMIT.
- Simultaneous DataMem_Read and nonzero DataMem_Write: treated as a write.
- A request deasserted before service is simply dropped; already-latched accesses complete normally.
- Request inputs are ignored outside IDLE; changes during ACCESS/RESP do not alter the latched access.
- Mem_Ack outside ACCESS is ignored.

Decomposition:
- Shared package mem_arb_pkg holds:
  - State enum (IDLE/ACCESS/RESP).
  - Port-id constants PORT_INST=0, PORT_DATA=1.
  - Default widths ADDR_W/DATA_W.
- One natural sub-module: mem_arb_wdog, the timeout counter. It has load/clear/enable inputs and an expire output, and is disabled when TIMEOUT=0.

Test Plan:
- Fetch only: InstMem_Read at 0x10, zero-wait memory with Mem_RData=0x2402000A → InstMem_Ready for 1 cycle, 2 cycles after sampling, InstMem_In=0x2402000A; no DataMem_Ready.
- Collision: Read and DataMem_Write=4'b1111 asserted together (addr 0x20, data 0xDEADBEEF) → data served first with Mem_Write=1111 and Mem_WData=0xDEADBEEF; fetch follows after 3 cycles.
- Starvation: continuous data reads plus a held fetch, STARVE_LIMIT=4 → exactly 4 data grants, then an inst grant, then the counter is back at 0.
- Wait states: Mem_Ack delayed 5 cycles → Mem_Req and address stable throughout; Ready 7 cycles after sampling.
- Timeout: TIMEOUT=8, Mem_Ack never arrives → Mem_Req drops; DataMem_Ready and Bus_Error pulse together with DataMem_In=0; next request is serviced normally.
- Reset mid-ACCESS: reset=0 for one edge → Mem_Req=0 next cycle, no Ready, FSM in IDLE, starve_cnt=0.
